down_counter16: RTL
===================

// Module: down_counter16
// PURPOSE
//  Loadable WIDTH-bit count-down timer; the decrementing counterpart of the PC-style up counter.
//  Software/CPU loads a start value, pulses or holds dec, and is told via tc/done when zero is reached.
//  Sits beside counter16 in the Hack-platform datapath as a delay/loop timer driven by the CPU.
// PARAMETERS
//  WIDTH   16   counter and data width in bits (unsigned arithmetic)
// PORTS
//  clk    in   1      system clock; all state changes on posedge
//  reset  in   1      synchronous, active-high reset
//  in     in   WIDTH  start value captured on load
//  load   in   1      load in into out, start run
//  dec    in   1      decrement enable, honoured only in RUN
//  ack    in   1      acknowledge done; returns DONE -> IDLE
//  out    out  WIDTH  current count (registered)
//  zero   out  1      combinational: out == 0
//  tc     out  1      terminal-count pulse, registered, one cycle wide
//  done   out  1      registered: state == DONE
// BEHAVIOUR
//  - Reset: out=0, tc=0, done=0, state=IDLE, zero=1; reload register=0. Reset overrides all inputs.
//  - States: IDLE (count 0, not armed), RUN (counting), DONE (expired, awaiting ack).
//  - Priority per cycle: reset > load > dec > ack.
//  - load (any state): out<=in; reload reg<=in; if in!=0 -> RUN, else -> IDLE; tc=0 that edge.
//  - RUN, dec=1, out>1: out<=out-1, stay RUN.
//  - RUN, dec=1, out==1: out<=0, tc<=1 next cycle, state -> DONE (see CONFIGURATION).
//  - RUN, dec=0: hold.
//  - dec in IDLE/DONE: ignored; out never wraps below 0 (no 0 -> all-ones underflow).
//  - DONE: out held at 0; ack=1 (and no load) -> IDLE; done deasserts same edge.
//  - ack in IDLE/RUN: ignored.
//  - tc: high exactly the one cycle after the terminal decrement edge, else 0; never on load.
//  - Latency: load/dec effect visible on out one clock after the sampling edge.
//  - Reset mid-RUN: next cycle out=0, IDLE, no tc.
// CONFIGURATION
//  Macro DOWN_COUNTER_AUTO_RELOAD_EN:
//  - Defined: terminal decrement in RUN loads out<=reload reg, pulses tc, stays RUN; DONE unreachable,
//    done tied 0, ack ignored. Periodic mode, period = loaded value.
//  - Undefined: one-shot behaviour as above (RUN -> DONE).
// STRUCTURE
//  - Shared package hack_pkg: WORD_WIDTH=16 constant, state typedef enum {ST_IDLE, ST_RUN, ST_DONE}
//    (2-bit encoding 00/01/10).
//  - Single module, no sub-modules: one next-state/next-count always block plus registered outputs.
// TESTING
//  1. reset=1 one cycle -> out=0, zero=1, tc=0, done=0.
//  2. load in=3, then dec=1 held -> out 3,2,1,0; tc=1 only in cycle out first reads 0; done=1 after.
//  3. load=1 and dec=1 same cycle, in=16'h10 -> out=16'h10 next cycle (load wins, no decrement).
//  4. dec=1 in IDLE for 4 cycles -> out stays 0, tc stays 0; ack in DONE -> done=0, state IDLE.
//  5. load 5, dec 2 cycles (out=3), reset=1 -> next cycle out=0, done=0, tc=0; no tc later.
//  6. With DOWN_COUNTER_AUTO_RELOAD_EN: load 2, dec held -> out 2,1,2,1,2; tc=1 on each return to 2;
//     done stays 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack-platform datapath definitions: word width and the timer state encoding.
package hack_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/down_counter16.sv
// Loadable count-down timer with terminal-count pulse and done/ack handshake.
// Optional periodic mode: define DOWN_COUNTER_AUTO_RELOAD_EN to reload on expiry instead of stopping.
module down_counter16
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             dec,
  input  logic             ack,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic             tc_r, tc_nxt_s;
  logic             done_r;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_r;
  logic             ack_unused_s;
  assign ack_unused_s = ack;

  // Reload register: remembers the period captured on the last load.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_r <= CNT_ZERO;
    end else if (load) begin
      reload_r <= in;
    end else begin
      reload_r <= reload_r;
    end
  end
`endif

  // Next-state / next-count logic; load beats dec, dec beats ack.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;
    if (load) begin
      count_nxt_s = in;
      state_nxt_s = (in != CNT_ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (dec) begin
            if (count_r > CNT_ONE) begin
              count_nxt_s = count_r - CNT_ONE;
            end else if (count_r == CNT_ONE) begin
              tc_nxt_s = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              count_nxt_s = reload_r;
`else
              count_nxt_s = CNT_ZERO;
              state_nxt_s = ST_DONE;
`endif
            end else begin
              // A zero count can never legitimately be running; park it safely.
              count_nxt_s = CNT_ZERO;
              state_nxt_s = ST_IDLE;
            end
          end else begin
            count_nxt_s = count_r;
          end
        end
        ST_DONE: begin
          count_nxt_s = CNT_ZERO;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          state_nxt_s = ST_IDLE;
`else
          if (ack) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
`endif
        end
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State, count and registered flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      done_r  <= 1'b0;
`else
      done_r  <= (state_nxt_s == ST_DONE);
`endif
    end
  end

  assign out  = count_r;
  assign zero = (count_r == CNT_ZERO);
  assign tc   = tc_r;
  assign done = done_r;

endmodule
